xgmii_tx_arbiter: RTL

Byte-wide XGMII transmit sequencer that shares one XGMII TX lane between two AXI-stream frame sources. It arbitrates round-robin at frame boundaries and frames each packet with Start, preamble, SFD and Terminate. It enforces a minimum inter-frame gap of idle characters and flags source underruns. It sits between the MAC-side frame queues and the XGMII source or sink used by the XGMII test bench.

---
 rtl/xgmii_tx_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/xgmii_tx_arbiter.sv
// Two-port AXI-stream to byte-wide XGMII TX sequencer: round-robin at frame boundaries,
// Start/preamble/SFD/Terminate framing, minimum IFG. Optional macro: XGMII_ARB_TUSER_ERR_EN.
module xgmii_tx_arbiter #(
    parameter int unsigned IFG_BYTES = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s0_tdata,
    input  logic       s0_tvalid,
    output logic       s0_tready,
    input  logic       s0_tlast,
    input  logic       s0_tuser,
    input  logic [7:0] s1_tdata,
    input  logic       s1_tvalid,
    output logic       s1_tready,
    input  logic       s1_tlast,
    input  logic       s1_tuser,
    output logic [7:0] xgmii_txd,
    output logic       xgmii_txc,
    output logic       grant,
    output logic       busy,
    output logic       underrun
);

    localparam logic [7:0] XG_IDLE  = 8'h07;
    localparam logic [7:0] XG_START = 8'hFB;
    localparam logic [7:0] XG_PRE   = 8'h55;
    localparam logic [7:0] XG_SFD   = 8'hD5;
    localparam logic [7:0] XG_TERM  = 8'hFD;
    localparam logic [7:0] XG_ERR   = 8'hFE;
    localparam logic [7:0] IFG_LOAD = 8'(IFG_BYTES - 1);
    localparam logic [2:0] PRE_LAST = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_TERM     = 3'd3,
        ST_IFG      = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] pre_cnt_q, pre_cnt_d;
    logic [7:0] ifg_cnt_q, ifg_cnt_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic [7:0] txd_q, txd_d;
    logic       txc_q, txc_d;
    logic       busy_q, busy_d;
    logic       underrun_q, underrun_d;

    logic [7:0] sel_tdata_s;
    logic       sel_tvalid_s;
    logic       sel_tlast_s;
    logic       pick_s;

`ifdef XGMII_ARB_TUSER_ERR_EN
    logic       sel_tuser_s;
    assign sel_tuser_s = grant_q ? s1_tuser : s0_tuser;
`else
    logic       unused_tuser_s;
    assign unused_tuser_s = s0_tuser ^ s1_tuser;
`endif

    // Beat fields of the port that owns the current frame
    always_comb begin
        if (grant_q) begin
            sel_tdata_s  = s1_tdata;
            sel_tvalid_s = s1_tvalid;
            sel_tlast_s  = s1_tlast;
        end else begin
            sel_tdata_s  = s0_tdata;
            sel_tvalid_s = s0_tvalid;
            sel_tlast_s  = s0_tlast;
        end
    end

    // Round-robin pick: on contention the port that did not go last wins
    always_comb begin
        pick_s = 1'b0;
        if (s0_tvalid && s1_tvalid) begin
            pick_s = ~last_q;
        end else if (s1_tvalid) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // Next-state, counters and next output character
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        ifg_cnt_d  = ifg_cnt_q;
        grant_d    = grant_q;
        last_d     = last_q;
        txd_d      = XG_IDLE;
        txc_d      = 1'b1;
        underrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s0_tvalid || s1_tvalid) begin
                    grant_d   = pick_s;
                    last_d    = pick_s;
                    pre_cnt_d = 3'd0;
                    txd_d     = XG_START;
                    txc_d     = 1'b1;
                    state_d   = ST_PREAMBLE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                txc_d = 1'b0;
                if (pre_cnt_q == PRE_LAST) begin
                    txd_d     = XG_SFD;
                    pre_cnt_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    txd_d     = XG_PRE;
                    pre_cnt_d = pre_cnt_q + 3'd1;
                end
            end
            ST_DATA: begin
                if (sel_tvalid_s) begin
                    txd_d = sel_tdata_s;
                    txc_d = 1'b0;
`ifdef XGMII_ARB_TUSER_ERR_EN
                    if (sel_tuser_s) begin
                        txd_d = XG_ERR;
                        txc_d = 1'b1;
                    end else begin
                        txc_d = 1'b0;
                    end
`endif
                    if (sel_tlast_s) begin
                        state_d = ST_TERM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    // Source starved mid-frame: poison the slot, keep the frame open
                    txd_d      = XG_ERR;
                    txc_d      = 1'b1;
                    underrun_d = 1'b1;
                end
            end
            ST_TERM: begin
                txd_d     = XG_TERM;
                txc_d     = 1'b1;
                ifg_cnt_d = IFG_LOAD;
                state_d   = ST_IFG;
            end
            ST_IFG: begin
                if (ifg_cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != ST_IDLE);

    // State, counters and registered XGMII outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pre_cnt_q  <= 3'd0;
            ifg_cnt_q  <= 8'd0;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            txd_q      <= XG_IDLE;
            txc_q      <= 1'b1;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            ifg_cnt_q  <= ifg_cnt_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            txd_q      <= txd_d;
            txc_q      <= txc_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end

    assign s0_tready = (state_q == ST_DATA) && !grant_q;
    assign s1_tready = (state_q == ST_DATA) &&  grant_q;
    assign xgmii_txd = txd_q;
    assign xgmii_txc = txc_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign underrun  = underrun_q;

endmodule
